// File: rtl/dmux_stream.sv
// rtl/dmux_stream.sv - one-to-N stream demultiplexer with per-channel output registers
//
// Purpose: routes each accepted input word to one channel (sel) or to every
// channel (bcast). Each channel holds a one-entry output register. Words sent
// to a non-existent channel are accepted, discarded and counted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    input word and its valid
//   in_ready            input accepted this cycle (combinational)
//   sel, bcast          destination channel / broadcast to all channels
//   out_data            channel i at bits [i*WIDTH +: WIDTH]
//   out_valid/out_ready per-channel handshake
//   drop_count          saturating count of words dropped for an illegal sel
//   err                 one-cycle pulse following each drop
module dmux_stream #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      bcast,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count,
    output logic                      err
);

    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(CHANNELS);

    logic                sel_legal;
    logic [CHANNELS-1:0] can_acc;
    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] load;
    logic                xfer;
    logic                drop;

    assign sel_legal = ({1'b0, sel} < NUM_CH);

    // A channel can take a word if it is empty or is draining this edge.
    assign can_acc = ~out_valid | out_ready;

    // One-hot decode of sel; all zero when sel names no channel.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_hit[i] = ({1'b0, sel} == (SEL_W + 1)'(i));
        end
    end

    // Broadcast waits for every channel so a partial broadcast never happens.
    // Illegal destinations are always ready so the word can be discarded.
    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &can_acc;
        end else if (sel_legal) begin
            in_ready = |(sel_hit & can_acc);
        end
    end

    assign xfer = in_valid & in_ready;
    assign drop = xfer & ~bcast & ~sel_legal;
    assign load = xfer ? (bcast ? {CHANNELS{1'b1}} : sel_hit) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_count <= '0;
            err        <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // A load wins over a drain, so a channel can pass one word per cycle.
                if (load[i]) begin
                    out_valid[i]                 <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i]                 <= 1'b0;
                end
            end
            err <= drop;
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// tb/tb_dmux_stream.sv - self-checking bench for dmux_stream
module tb_dmux_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic        bcast;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_count;
    logic        err;

    // Three-channel instance for the illegal-select saturation case.
    logic [15:0] in_data3;
    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  sel3;
    logic        bcast3;
    logic [47:0] out_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [7:0]  drop_count3;
    logic        err3;

    int n_checks = 0;
    int n_errors = 0;

    dmux_stream #(.WIDTH(16), .CHANNELS(4), .SEL_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .bcast(bcast), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count), .err(err)
    );

    dmux_stream #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .bcast(bcast3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .drop_count(drop_count3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each channel currently holds, plus drop bookkeeping.
    bit          m_full [4];
    logic [15:0] m_dat  [4];
    int          m_cnt;
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < 4; c++) begin
            m_full[c] = 1'b0;
            m_dat[c]  = 16'h0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endfunction

    function automatic bit m_ready();
        bit all_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (m_full[c] && !out_ready[c]) all_ok = 1'b0;
        end
        if (bcast) return all_ok;
        if (int'(sel) >= 4) return 1'b1;
        return !m_full[int'(sel)] || out_ready[int'(sel)];
    endfunction

    task automatic check_outs(input string tag);
        logic [3:0] ev;
        for (int c = 0; c < 4; c++) ev[c] = m_full[c];
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        for (int c = 0; c < 4; c++) begin
            if (m_full[c]) chk($sformatf("%s.data%0d", tag, c), 64'(out_data[c*16 +: 16]), 64'(m_dat[c]));
        end
        chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_cnt));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
    endtask

    // Check in_ready for the current inputs, advance one edge, then check outputs.
    task automatic tick(input string tag);
        bit          fire;
        bit          n_full [4];
        logic [15:0] n_dat  [4];
        bit          dropped;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready()));
        fire    = in_valid && m_ready();
        dropped = fire && !bcast && (int'(sel) >= 4);
        for (int c = 0; c < 4; c++) begin
            n_dat[c] = m_dat[c];
            if (fire && (bcast || int'(sel) == c)) begin
                n_full[c] = 1'b1;
                n_dat[c]  = in_data;
            end else if (out_ready[c]) begin
                n_full[c] = 1'b0;
            end else begin
                n_full[c] = m_full[c];
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            m_full[c] = n_full[c];
            m_dat[c]  = n_dat[c];
        end
        if (dropped && m_cnt < 255) m_cnt++;
        m_err = dropped;
        check_outs(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        sel        = '0;
        bcast      = 1'b0;
        out_ready  = '0;
        in_data3   = 16'hC0DE;
        in_valid3  = 1'b0;
        sel3       = '0;
        bcast3     = 1'b0;
        out_ready3 = '1;
        m_reset();

        // Reset state
        @(posedge clk);
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'h0);
        chk("rst.out_data", out_data, 64'h0);
        chk("rst.drop_count", 64'(drop_count), 64'h0);
        chk("rst.err", 64'(err), 64'h0);
        chk("rst.out_valid3", 64'(out_valid3), 64'h0);
        rst_n = 1'b1;

        // Single unicast word to channel 2, then drain
        out_ready = 4'b1111;
        in_data = 16'h1234; sel = 4'd2; in_valid = 1'b1;
        tick("uni");
        chk("uni.vec", 64'(out_valid), 64'h4);
        chk("uni.ch2", 64'(out_data[32 +: 16]), 64'h1234);
        in_valid = 1'b0;
        tick("uni_drain");
        chk("uni_drain.vec", 64'(out_valid), 64'h0);

        // Stalled channel 1, then simultaneous drain and load
        out_ready = 4'b1101;
        in_data = 16'hAAAA; sel = 4'd1; in_valid = 1'b1;
        tick("stall_a");
        in_data = 16'hBBBB;
        tick("stall_b");
        chk("stall_b.ch1", 64'(out_data[16 +: 16]), 64'hAAAA);
        out_ready = 4'b1111;
        tick("swap");
        chk("swap.ch1", 64'(out_data[16 +: 16]), 64'hBBBB);
        chk("swap.v1", 64'(out_valid[1]), 64'h1);
        in_valid = 1'b0;
        tick("swap_drain");

        // Broadcast blocked by stalled channel 3, then released
        out_ready = 4'b0111;
        in_data = 16'h3333; sel = 4'd3; in_valid = 1'b1;
        tick("bc_fill");
        in_data = 16'h00FF; bcast = 1'b1;
        tick("bc_block");
        chk("bc_block.vec", 64'(out_valid), 64'h8);
        chk("bc_block.ch3", 64'(out_data[48 +: 16]), 64'h3333);
        out_ready = 4'b1111;
        tick("bc_go");
        chk("bc_go.vec", 64'(out_valid), 64'hF);
        chk("bc_go.data", out_data, 64'h00FF_00FF_00FF_00FF);
        in_valid = 1'b0; bcast = 1'b0;
        tick("bc_drain");

        // Back-to-back words 1..8 to channel 0
        sel = 4'd0; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = 16'(k);
            tick("b2b");
            chk("b2b.ch0", 64'(out_data[15:0]), 64'(k));
            chk("b2b.v0", 64'(out_valid[0]), 64'h1);
        end
        in_valid = 1'b0;
        tick("b2b_drain");

        // Illegal select on the 3-channel instance, saturating the counter
        in_valid3 = 1'b1; sel3 = 2'd3;
        for (int k = 1; k <= 300; k++) begin
            tick("sat_main");
            chk("sat.in_ready3", 64'(in_ready3), 64'h1);
            chk("sat.err3", 64'(err3), 64'h1);
            chk("sat.drop_count3", 64'(drop_count3), 64'((k > 255) ? 255 : k));
            chk("sat.out_valid3", 64'(out_valid3), 64'h0);
        end
        in_valid3 = 1'b0;
        tick("sat_end");
        chk("sat_end.err3", 64'(err3), 64'h0);
        chk("sat_end.drop_count3", 64'(drop_count3), 64'd255);

        // Randomized traffic, including illegal selects and broadcasts
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            sel       = 4'($urandom_range(0, 6));
            bcast     = ($urandom_range(0, 7) == 0);
            out_ready = 4'($urandom);
            tick("rand");
        end
        in_valid = 1'b0; bcast = 1'b0;
        out_ready = 4'b1111;
        tick("rand_drain");

        // Illegal select on the main instance leaves channels untouched
        out_ready = 4'b0000;
        in_data = 16'h1111; sel = 4'd0; in_valid = 1'b1;
        tick("pre_rst_a");
        in_data = 16'h2222; sel = 4'd1;
        tick("pre_rst_b");
        in_data = 16'hDEAD; sel = 4'd9;
        tick("illegal");
        chk("illegal.vec", 64'(out_valid), 64'h3);
        in_valid = 1'b0;
        tick("illegal_err");

        // Asynchronous reset between edges with two channels full
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst.out_valid", 64'(out_valid), 64'h0);
        chk("arst.out_data", out_data, 64'h0);
        chk("arst.drop_count", 64'(drop_count), 64'h0);
        chk("arst.err", 64'(err), 64'h0);
        #2;
        rst_n = 1'b1;
        out_ready = 4'b1111;
        in_data = 16'h5A5A; sel = 4'd2; in_valid = 1'b1;
        tick("post_rst");
        chk("post_rst.ch2", 64'(out_data[32 +: 16]), 64'h5A5A);
        in_valid = 1'b0;
        tick("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmux_stream.md
DMUX_STREAM -- requirements
Module: dmux_stream

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter CHANNELS, default 4, number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 4, select width in bits, SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-004 CLK  input  1  single clock; all state SHALL change on the rising edge only.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 IN_DATA  input  WIDTH  input word.
REQ-007 IN_VALID  input  1  input word present.
REQ-008 IN_READY  output  1  block accepts the input word this cycle.
REQ-009 SEL  input  SEL_W  destination channel, sampled with IN_DATA.
REQ-010 BCAST  input  1  when high, the word goes to all channels and SEL is ignored.
REQ-011 OUT_DATA  output  CHANNELS*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 OUT_VALID  output  CHANNELS  per-channel valid.
REQ-013 OUT_READY  input  CHANNELS  per-channel consumer ready.
REQ-014 DROP_COUNT  output  8  count of words dropped for an illegal SEL.
REQ-015 ERR  output  1  one-cycle pulse on each drop.

Function
REQ-016 Transfer rule: a transfer SHALL occur on a rising edge when VALID and READY are both high; the input side and each output channel follow this rule independently.
REQ-017 Each channel SHALL hold a one-entry output register with two states:
- EMPTY: OUT_VALID[i]=0.
- FULL: OUT_VALID[i]=1.
REQ-018 Per-channel accept term SHALL be can_acc[i] = EMPTY[i] OR OUT_READY[i].
REQ-019 IN_READY SHALL be combinational:
- BCAST=1: AND of can_acc over all channels.
- BCAST=0 and SEL<CHANNELS: can_acc[SEL].
- BCAST=0 and SEL>=CHANNELS: 1.
REQ-020 Unicast transfer (BCAST=0, SEL legal): OUT_DATA of channel SEL SHALL load IN_DATA and that channel SHALL go FULL on the same edge; no other channel changes except through its own drain.
REQ-021 Broadcast transfer: every channel SHALL load IN_DATA and go FULL on the same edge; a partial broadcast SHALL never occur.
REQ-022 Latency SHALL be one cycle: a word accepted at edge k is visible on OUT_DATA/OUT_VALID after edge k.
REQ-023 Drain: when FULL[i] and OUT_READY[i] are high and no new load targets channel i, the channel SHALL go EMPTY.
REQ-024 Simultaneous drain and load on one channel SHALL leave the channel FULL holding the new word, giving one word per cycle sustained throughput.
REQ-025 While OUT_VALID[i]=1 and OUT_READY[i]=0, OUT_DATA channel i SHALL remain stable.
REQ-026 OUT_DATA of an EMPTY channel SHALL retain its last value; its content is don't-care.
REQ-027 Illegal SEL (BCAST=0, SEL>=CHANNELS, IN_VALID=1): the word SHALL be accepted and discarded.
- DROP_COUNT SHALL increment by 1, saturating at 255.
- ERR SHALL be high for the following cycle.
- No channel SHALL change.
REQ-028 IN_VALID=0 SHALL cause no load, no drop and no ERR, regardless of SEL and BCAST.
REQ-029 The block SHALL NOT depend on IN_VALID remaining asserted; the upstream may change IN_DATA, SEL or BCAST whenever no transfer occurs.

Reset
REQ-030 On RST_N low, the block SHALL immediately and asynchronously:
- set all channels EMPTY (OUT_VALID=0);
- set OUT_DATA=0, DROP_COUNT=0 and ERR=0.
REQ-031 While RST_N is low, no transfer, drop or count SHALL occur.
REQ-032 A reset mid-operation SHALL discard all buffered words.
REQ-033 The first transfer after release SHALL be possible on the first rising edge with RST_N high.

Verification
REQ-034 Defaults; IN_DATA=16'h1234, SEL=2, IN_VALID=1 for one cycle, all OUT_READY=1 -> next cycle OUT_VALID=4'b0100, channel 2 data 16'h1234; then OUT_VALID=0.
REQ-035 Channel 1 FULL with 16'hAAAA, OUT_READY[1]=0; send 16'hBBBB to SEL=1 -> IN_READY=0, channel 1 holds 16'hAAAA; raise OUT_READY[1] -> same edge drains AAAA and loads BBBB, OUT_VALID[1] stays 1.
REQ-036 BCAST=1 with 16'h00FF while channel 3 is FULL and stalled -> IN_READY=0 and no channel loads; release OUT_READY[3] -> all four channels show 16'h00FF, OUT_VALID=4'b1111.
REQ-037 CHANNELS=3, SEL=3, IN_VALID=1 for 300 cycles -> IN_READY=1 throughout, ERR pulses each cycle after a drop, DROP_COUNT saturates at 255, OUT_VALID stays 0.
REQ-038 Back-to-back words 1..8 to SEL=0 with OUT_READY[0]=1 -> channel 0 emits 1..8 on consecutive cycles with no gaps.
REQ-039 Assert RST_N low between edges while two channels are FULL -> OUT_VALID=0, OUT_DATA=0 and DROP_COUNT=0 before the next edge; after release, a new word transfers on the first edge.
